// File: rtl/bp_be_late_wb_arbiter.sv
// Late-writeback arbiter: one holding buffer per long-latency producer,
// round-robin selection among full buffers, a selection lock held under
// backpressure, and a starvation counter that raises a force request.
module bp_be_late_wb_arbiter #(
   parameter int num_src_p        = 3,
   parameter int data_width_p     = 64,
   parameter int reg_addr_width_p = 5,
   parameter int fflags_width_p   = 5,
   parameter int starve_limit_p   = 8
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,

   input  logic [num_src_p-1:0]                   src_v_i,
   output logic [num_src_p-1:0]                   src_ready_and_o,
   input  logic [num_src_p*reg_addr_width_p-1:0]  src_rd_addr_i,
   input  logic [num_src_p*data_width_p-1:0]      src_rd_data_i,
   input  logic [num_src_p-1:0]                   src_ird_w_v_i,
   input  logic [num_src_p-1:0]                   src_frd_w_v_i,
   input  logic [num_src_p-1:0]                   src_ptw_w_v_i,
   input  logic [num_src_p*fflags_width_p-1:0]    src_fflags_i,

   output logic                                   late_wb_v_o,
   output logic                                   late_wb_force_o,
   output logic [reg_addr_width_p-1:0]            late_wb_rd_addr_o,
   output logic [data_width_p-1:0]                late_wb_rd_data_o,
   output logic                                   late_wb_ird_w_v_o,
   output logic                                   late_wb_frd_w_v_o,
   output logic                                   late_wb_ptw_w_v_o,
   output logic [fflags_width_p-1:0]              late_wb_fflags_o,
   input  logic                                   late_wb_yumi_i,
   output logic [$clog2(num_src_p)-1:0]           late_wb_src_o
);

   localparam int sel_w_lp = $clog2(num_src_p);
   localparam int idx_w_lp = sel_w_lp + 1;
   localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
   localparam logic [sel_w_lp-1:0] last_src_lp  = sel_w_lp'(num_src_p - 1);
   localparam logic [cnt_w_lp-1:0] starve_max_lp = cnt_w_lp'(starve_limit_p);

   logic [num_src_p-1:0]         buf_v_r;
   logic [reg_addr_width_p-1:0]  buf_rd_addr_r [num_src_p];
   logic [data_width_p-1:0]      buf_rd_data_r [num_src_p];
   logic [num_src_p-1:0]         buf_ird_r;
   logic [num_src_p-1:0]         buf_frd_r;
   logic [num_src_p-1:0]         buf_ptw_r;
   logic [fflags_width_p-1:0]    buf_fflags_r  [num_src_p];

   logic [sel_w_lp-1:0]          rr_ptr_r;
   logic [sel_w_lp-1:0]          lock_sel_r;
   logic                         lock_v_r;
   logic [cnt_w_lp-1:0]          wait_cnt_r;

   logic [sel_w_lp-1:0]          rr_sel;
   logic [idx_w_lp-1:0]          scan_idx;
   logic [sel_w_lp-1:0]          sel;
   logic                         any_v;
   logic [num_src_p-1:0]         deq;
   logic [num_src_p-1:0]         enq;

   // Round-robin scan from rr_ptr; scanning farthest-first lets the nearest valid buffer win
   always_comb begin
      rr_sel   = rr_ptr_r;
      scan_idx = '0;
      for (int unsigned k = 0; k < num_src_p; k++) begin
         scan_idx = {1'b0, rr_ptr_r} + idx_w_lp'(num_src_p - 1 - k);
         if (scan_idx >= idx_w_lp'(num_src_p))
            scan_idx = scan_idx - idx_w_lp'(num_src_p);
         if (buf_v_r[scan_idx[sel_w_lp-1:0]])
            rr_sel = scan_idx[sel_w_lp-1:0];
      end
   end

   assign sel   = lock_v_r ? lock_sel_r : rr_sel;
   assign any_v = |buf_v_r;

   // Per-source drain on accept and enqueue handshake (drain and refill may coincide)
   always_comb begin
      deq = '0;
      for (int unsigned i = 0; i < num_src_p; i++)
         deq[i] = late_wb_yumi_i & (sel == sel_w_lp'(i));
      src_ready_and_o = ~buf_v_r | deq;
      enq             = src_v_i & src_ready_and_o;
   end

   // Buffer valid bits: refill takes precedence over drain
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         buf_v_r <= '0;
      else
         buf_v_r <= (buf_v_r & ~deq) | enq;
   end

   // Buffer payload capture; contents are only observed while valid, so no reset
   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < num_src_p; i++) begin
         if (enq[i]) begin
            buf_rd_addr_r[i] <= src_rd_addr_i[i*reg_addr_width_p +: reg_addr_width_p];
            buf_rd_data_r[i] <= src_rd_data_i[i*data_width_p +: data_width_p];
            buf_ird_r[i]     <= src_ird_w_v_i[i];
            buf_frd_r[i]     <= src_frd_w_v_i[i];
            buf_ptw_r[i]     <= src_ptw_w_v_i[i];
            buf_fflags_r[i]  <= src_fflags_i[i*fflags_width_p +: fflags_width_p];
         end
      end
   end

   // Round-robin pointer, selection lock and starvation counter
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rr_ptr_r   <= '0;
         lock_v_r   <= 1'b0;
         lock_sel_r <= '0;
         wait_cnt_r <= '0;
      end else if (late_wb_yumi_i) begin
         rr_ptr_r   <= (sel == last_src_lp) ? '0 : sel + sel_w_lp'(1);
         lock_v_r   <= 1'b0;
         wait_cnt_r <= '0;
      end else if (any_v) begin
         lock_v_r   <= 1'b1;
         lock_sel_r <= sel;
         if (wait_cnt_r != starve_max_lp)
            wait_cnt_r <= wait_cnt_r + cnt_w_lp'(1);
      end
   end

   // Output mux from the selected buffer; all payload forced to zero when idle
   always_comb begin
      late_wb_v_o       = any_v;
      late_wb_force_o   = any_v & (wait_cnt_r == starve_max_lp);
      late_wb_rd_addr_o = '0;
      late_wb_rd_data_o = '0;
      late_wb_ird_w_v_o = 1'b0;
      late_wb_frd_w_v_o = 1'b0;
      late_wb_ptw_w_v_o = 1'b0;
      late_wb_fflags_o  = '0;
      late_wb_src_o     = '0;
      if (any_v) begin
         late_wb_rd_addr_o = buf_rd_addr_r[sel];
         late_wb_rd_data_o = buf_rd_data_r[sel];
         late_wb_ird_w_v_o = buf_ird_r[sel];
         late_wb_frd_w_v_o = buf_frd_r[sel];
         late_wb_ptw_w_v_o = buf_ptw_r[sel];
         late_wb_fflags_o  = buf_fflags_r[sel];
         late_wb_src_o     = sel;
      end
   end

   // Accepting with nothing presented is a consumer protocol error
   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      late_wb_yumi_i |-> late_wb_v_o);

   // A single writeback may target the integer or the FP file, never both
   for (genvar g = 0; g < num_src_p; g++) begin : g_we_chk
      single_rf_write: assert property (@(posedge clk_i) disable iff (reset_i)
         enq[g] |-> !(src_ird_w_v_i[g] && src_frd_w_v_i[g]));
   end

endmodule

// File: doc/bp_be_late_wb_arbiter.md
Name: bp_be_late_wb_arbiter

Overview:
Merges several long-latency writeback producers into the single late-writeback channel consumed by the scheduler. Producers include the FP divide/sqrt unit, the integer divide unit and the dcache miss/PTW return path. Each producer gets a one-entry holding buffer. The block round-robin arbitrates among full buffers and holds a selection stable under backpressure. It raises a force request when the winner has been refused too long, so that late writebacks preempt issue instead of starving.

Parameters:
num_src_p, 3, number of writeback producers (>=2)
data_width_p, 64, writeback data width
reg_addr_width_p, 5, architectural register index width
fflags_width_p, 5, floating-point exception flag width
starve_limit_p, 8, refused cycles before force asserts (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
src_v_i  in  num_src_p  per-source writeback valid
src_ready_and_o  out  num_src_p  per-source ready (valid/ready-and handshake)
src_rd_addr_i  in  num_src_p*reg_addr_width_p  destination register per source
src_rd_data_i  in  num_src_p*data_width_p  writeback data per source
src_ird_w_v_i  in  num_src_p  integer RF write enable per source
src_frd_w_v_i  in  num_src_p  FP RF write enable per source
src_ptw_w_v_i  in  num_src_p  data is a PTE return for the walker
src_fflags_i  in  num_src_p*fflags_width_p  fflags per source
late_wb_v_o  out  1  a writeback is presented
late_wb_force_o  out  1  request to preempt issue for this writeback
late_wb_rd_addr_o  out  reg_addr_width_p  selected rd address
late_wb_rd_data_o  out  data_width_p  selected data
late_wb_ird_w_v_o  out  1  selected integer write enable
late_wb_frd_w_v_o  out  1  selected FP write enable
late_wb_ptw_w_v_o  out  1  selected PTW flag
late_wb_fflags_o  out  fflags_width_p  selected fflags
late_wb_yumi_i  in  1  consumer accepts the presented writeback this cycle
late_wb_src_o  out  $clog2(num_src_p)  index of the selected source (debug/tracing)

Behaviour:
- Clocking and reset: one clock, clk_i. reset_i is asynchronous and active-high.
- Reset clears:
  - all buffer valid bits
  - rr_ptr=0, lock_v=0, wait_cnt=0
- Outputs during reset and after reset, until the first enqueue: late_wb_v_o=0, late_wb_force_o=0, src_ready_and_o=all 1s, payload outputs 0.
- Buffer i holds {rd_addr, data, ird_w_v, frd_w_v, ptw_w_v, fflags, v}.
- src_ready_and_o[i] = ~buf_v[i] | (late_wb_yumi_i & sel==i). A same-cycle drain and refill is legal.
- Enqueue: src_v_i[i] & src_ready_and_o[i] captures the payload at the clock edge.
- Latency: minimum 1 cycle from enqueue to late_wb_v_o. There is no combinational input-to-output path.
- late_wb_v_o = |buf_v. Payload outputs are muxed from buf[sel]. Non-selected payload is don't-care when v=0 (drive 0).
- Selection:
  - sel = lock_v ? lock_sel : first valid buffer scanning rr_ptr, rr_ptr+1, ... mod num_src_p.
  - lock_v<=1 and lock_sel<=sel when late_wb_v_o & ~late_wb_yumi_i. The presented payload and sel stay stable until yumi, even if higher-priority buffers fill.
- On late_wb_yumi_i:
  - buf_v[sel] cleared, unless refilled the same cycle.
  - rr_ptr <= (sel+1) mod num_src_p; wrap is non-power-of-2 safe.
  - lock_v<=0, wait_cnt<=0.
- Starvation counter:
  - wait_cnt (width $clog2(starve_limit_p+1)) increments each cycle late_wb_v_o & ~late_wb_yumi_i, saturating at starve_limit_p.
  - late_wb_force_o = late_wb_v_o & (wait_cnt==starve_limit_p). It is registered-derived, with no combinational dependence on yumi.
  - Force stays high until yumi.
- late_wb_yumi_i while late_wb_v_o=0 is illegal. The implementation carries a simulation assertion for it.
- Write enables: ird_w_v and frd_w_v both set in one entry is illegal (assertion). ptw_w_v with either write enable set is legal.
- No flush input. Accepted writebacks are architecturally committed and are always delivered.
- Reset asserted mid-operation drops all buffered entries immediately and asynchronously. Outputs go to reset values within the same cycle.

Test Plan:
- Single source: src 1 sends rd=7, data=0xDEAD, ird=1 at cycle 0. Expect v_o=1, src_o=1, rd=7, data=0xDEAD at cycle 1. yumi at cycle 1 -> v_o=0 at cycle 2, rr_ptr=2.
- Contention: all 3 sources valid at cycle 0 with rr_ptr=0, yumi held high. Grants go 0,1,2 on cycles 1,2,3. Sources refill immediately -> grants continue 0,1,2.
- Backpressure stability: src 2 presented, yumi low 4 cycles while src 0 fills. Payload and src_o stay =2 throughout. After yumi, src 0 is presented next cycle.
- Starvation: one entry presented, yumi held low. force_o=0 for refused cycles 1-8 and rises on cycle 9 (wait_cnt=8). yumi -> force_o=0 and wait_cnt=0 the next cycle.
- Drain/refill: src 0 buffered and selected, src_v_i[0] high with new data on the yumi cycle. ready_and_o[0]=1 that cycle. New data is presented on the next cycle only if no other source wins round-robin.
- Reset mid-operation: 3 full buffers, force asserted. Pulse reset_i off a clock edge. v_o, force_o and payload go to 0 immediately, and ready_and_o=111.
